// File: rtl/id_ex_stage.sv
// id_ex_stage: decode-to-execute pipeline register with M/W operand forwarding and load-use detection.
// Define ID_EX_FWD_EN to enable forwarding; without it operands come straight from the register file.
module id_ex_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_e,
    input  logic            flush_e,
    input  logic            valid_d,
    input  logic [XLEN-1:0] PC_d,
    input  logic [6:0]      opcode_d,
    input  logic [3:0]      ALUControl_d,
    input  logic            ALUSrc_d,
    input  logic [XLEN-1:0] RD1_d,
    input  logic [XLEN-1:0] RD2_d,
    input  logic [XLEN-1:0] ImmExt_d,
    input  logic [4:0]      Rs1_d,
    input  logic [4:0]      Rs2_d,
    input  logic [4:0]      Rd_d,
    input  logic            RegWrite_d,
    input  logic            MemWrite_d,
    input  logic            Branch_d,
    input  logic            Jump_d,
    input  logic [1:0]      ResultSrc_d,
    input  logic            RegWrite_m,
    input  logic [4:0]      Rd_m,
    input  logic [XLEN-1:0] ALUResult_m,
    input  logic            RegWrite_w,
    input  logic [4:0]      Rd_w,
    input  logic [XLEN-1:0] Result_w,
    output logic [XLEN-1:0] SrcA,
    output logic [XLEN-1:0] SrcB,
    output logic [3:0]      ALUControl,
    output logic [XLEN-1:0] PC,
    output logic [6:0]      opcode,
    output logic [XLEN-1:0] WriteData_e,
    output logic [4:0]      Rd_e,
    output logic            RegWrite_e,
    output logic            MemWrite_e,
    output logic            Branch_e,
    output logic            Jump_e,
    output logic            valid_e,
    output logic [1:0]      ResultSrc_e,
    output logic            lu_hazard
);
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [6:0]      op;
        logic [3:0]      alu_ctrl;
        logic            alu_src;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            reg_write;
        logic            mem_write;
        logic            branch;
        logic            jump;
        logic [1:0]      result_src;
    } e_t;

    e_t e_q, e_d, cap;
    logic [XLEN-1:0] fwd_a, fwd_b;
    logic            lu_kind;

    always_comb begin
        cap = '{valid: valid_d, pc: PC_d, op: opcode_d, alu_ctrl: ALUControl_d,
                alu_src: ALUSrc_d, rd1: RD1_d, rd2: RD2_d, imm: ImmExt_d,
                rs1: Rs1_d, rs2: Rs2_d, rd: Rd_d, reg_write: RegWrite_d,
                mem_write: MemWrite_d, branch: Branch_d, jump: Jump_d,
                result_src: ResultSrc_d};
        e_d = flush_e ? '0 : stall_e ? e_q : cap;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) e_q <= '0;
        else        e_q <= e_d;

`ifdef ID_EX_FWD_EN
    // M beats W; x0 is never forwarded.
    function automatic logic [XLEN-1:0] fwd(input logic [4:0] rs, input logic [XLEN-1:0] rf);
        return (RegWrite_m && Rd_m == rs && rs != 5'd0) ? ALUResult_m :
               (RegWrite_w && Rd_w == rs && rs != 5'd0) ? Result_w : rf;
    endfunction

    always_comb begin
        fwd_a   = fwd(e_q.rs1, e_q.rd1);
        fwd_b   = fwd(e_q.rs2, e_q.rd2);
        lu_kind = e_q.result_src == 2'b01;
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{RegWrite_m, Rd_m, ALUResult_m, RegWrite_w, Rd_w, Result_w};

    // Without forwarding any pending E-stage write is a hazard, not only loads.
    always_comb begin
        fwd_a   = e_q.rd1;
        fwd_b   = e_q.rd2;
        lu_kind = 1'b1;
    end
`endif

    always_comb begin
        SrcA        = fwd_a;
        SrcB        = e_q.alu_src ? e_q.imm : fwd_b;
        WriteData_e = fwd_b;
        lu_hazard   = e_q.valid & e_q.reg_write & lu_kind & (e_q.rd != 5'd0) &
                      (e_q.rd == Rs1_d | e_q.rd == Rs2_d);
        ALUControl  = e_q.alu_ctrl;
        PC          = e_q.pc;
        opcode      = e_q.op;
        Rd_e        = e_q.rd;
        RegWrite_e  = e_q.reg_write;
        MemWrite_e  = e_q.mem_write;
        Branch_e    = e_q.branch;
        Jump_e      = e_q.jump;
        valid_e     = e_q.valid;
        ResultSrc_e = e_q.result_src;
    end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed and randomized checks of id_ex_stage against a behavioural model.
module tb_id_ex_stage;
    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    logic stall_e, flush_e, valid_d, ALUSrc_d, RegWrite_d, MemWrite_d, Branch_d, Jump_d;
    logic [31:0] PC_d, RD1_d, RD2_d, ImmExt_d, ALUResult_m, Result_w;
    logic [6:0]  opcode_d;
    logic [3:0]  ALUControl_d;
    logic [4:0]  Rs1_d, Rs2_d, Rd_d, Rd_m, Rd_w;
    logic [1:0]  ResultSrc_d;
    logic        RegWrite_m, RegWrite_w;
    logic [31:0] SrcA, SrcB, PC, WriteData_e;
    logic [3:0]  ALUControl;
    logic [6:0]  opcode;
    logic [4:0]  Rd_e;
    logic        RegWrite_e, MemWrite_e, Branch_e, Jump_e, valid_e, lu_hazard;
    logic [1:0]  ResultSrc_e;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .stall_e(stall_e), .flush_e(flush_e), .valid_d(valid_d),
        .PC_d(PC_d), .opcode_d(opcode_d), .ALUControl_d(ALUControl_d), .ALUSrc_d(ALUSrc_d),
        .RD1_d(RD1_d), .RD2_d(RD2_d), .ImmExt_d(ImmExt_d), .Rs1_d(Rs1_d), .Rs2_d(Rs2_d),
        .Rd_d(Rd_d), .RegWrite_d(RegWrite_d), .MemWrite_d(MemWrite_d), .Branch_d(Branch_d),
        .Jump_d(Jump_d), .ResultSrc_d(ResultSrc_d), .RegWrite_m(RegWrite_m), .Rd_m(Rd_m),
        .ALUResult_m(ALUResult_m), .RegWrite_w(RegWrite_w), .Rd_w(Rd_w), .Result_w(Result_w),
        .SrcA(SrcA), .SrcB(SrcB), .ALUControl(ALUControl), .PC(PC), .opcode(opcode),
        .WriteData_e(WriteData_e), .Rd_e(Rd_e), .RegWrite_e(RegWrite_e), .MemWrite_e(MemWrite_e),
        .Branch_e(Branch_e), .Jump_e(Jump_e), .valid_e(valid_e), .ResultSrc_e(ResultSrc_e),
        .lu_hazard(lu_hazard)
    );

    typedef struct {
        logic        valid, alu_src, rw, mw, br, jp;
        logic [31:0] pc, rd1, rd2, imm;
        logic [6:0]  op;
        logic [3:0]  alu;
        logic [4:0]  rs1, rs2, rd;
        logic [1:0]  res;
    } e_t;

    e_t m, empty;
    int total = 0, bad = 0;
    logic [31:0] saved_pc;

    function automatic e_t d_now();
        e_t x;
        x.valid = valid_d; x.alu_src = ALUSrc_d; x.rw = RegWrite_d; x.mw = MemWrite_d;
        x.br = Branch_d; x.jp = Jump_d; x.pc = PC_d; x.rd1 = RD1_d; x.rd2 = RD2_d;
        x.imm = ImmExt_d; x.op = opcode_d; x.alu = ALUControl_d; x.rs1 = Rs1_d;
        x.rs2 = Rs2_d; x.rd = Rd_d; x.res = ResultSrc_d;
        return x;
    endfunction

    function automatic logic [31:0] exp_fwd(input logic [4:0] rs, input logic [31:0] rf);
`ifdef ID_EX_FWD_EN
        if (rs != 0 && RegWrite_m && Rd_m == rs) return ALUResult_m;
        if (rs != 0 && RegWrite_w && Rd_w == rs) return Result_w;
`endif
        return rf;
    endfunction

    function automatic logic exp_lu();
        logic kind;
`ifdef ID_EX_FWD_EN
        kind = (m.res == 2'b01);
`else
        kind = 1'b1;
`endif
        return m.valid && m.rw && kind && m.rd != 0 && (m.rd == Rs1_d || m.rd == Rs2_d);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string ph);
        chk({ph, ".SrcA"}, SrcA, exp_fwd(m.rs1, m.rd1));
        chk({ph, ".SrcB"}, SrcB, m.alu_src ? m.imm : exp_fwd(m.rs2, m.rd2));
        chk({ph, ".WriteData"}, WriteData_e, exp_fwd(m.rs2, m.rd2));
        chk({ph, ".lu"}, {31'd0, lu_hazard}, {31'd0, exp_lu()});
        chk({ph, ".PC"}, PC, m.pc);
        chk({ph, ".ctl"}, {ALUControl, opcode, Rd_e, ResultSrc_e, RegWrite_e, MemWrite_e, Branch_e, Jump_e, valid_e},
            {m.alu, m.op, m.rd, m.res, m.rw, m.mw, m.br, m.jp, m.valid});
    endtask

    task automatic tick();
        e_t nx;
        nx = flush_e ? empty : stall_e ? m : d_now();
        @(posedge clk);
        if (rst_n) m = nx;
        #1;
    endtask

    task automatic rand_d();
        valid_d = 1'($urandom); PC_d = $urandom; opcode_d = 7'($urandom);
        ALUControl_d = 4'($urandom); ALUSrc_d = 1'($urandom); RD1_d = $urandom;
        RD2_d = $urandom; ImmExt_d = $urandom; Rs1_d = 5'($urandom_range(0, 7));
        Rs2_d = 5'($urandom_range(0, 7)); Rd_d = 5'($urandom_range(0, 7));
        RegWrite_d = 1'($urandom); MemWrite_d = 1'($urandom); Branch_d = 1'($urandom);
        Jump_d = 1'($urandom); ResultSrc_d = 2'($urandom_range(0, 2));
    endtask

    task automatic rand_mw();
        RegWrite_m = 1'($urandom); Rd_m = 5'($urandom_range(0, 7)); ALUResult_m = $urandom;
        RegWrite_w = 1'($urandom); Rd_w = 5'($urandom_range(0, 7)); Result_w = $urandom;
    endtask

    task automatic clear_d();
        valid_d = 1; PC_d = 0; opcode_d = 7'h33; ALUControl_d = 0; ALUSrc_d = 0;
        RD1_d = 0; RD2_d = 0; ImmExt_d = 0; Rs1_d = 0; Rs2_d = 0; Rd_d = 0;
        RegWrite_d = 0; MemWrite_d = 0; Branch_d = 0; Jump_d = 0; ResultSrc_d = 0;
        RegWrite_m = 0; Rd_m = 0; ALUResult_m = 0; RegWrite_w = 0; Rd_w = 0; Result_w = 0;
    endtask

    initial begin
        empty = '{default: '0};
        m = empty;
        stall_e = 0; flush_e = 0;
        // Reset held with random D inputs
        rand_d(); rand_mw();
        #1 check_all("rst");
        chk("rst.valid", {31'd0, valid_e}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            rand_d(); rand_mw(); tick(); check_all("rst_hold");
        end
        chk("rst.PC", PC, 32'd0);
        @(negedge clk) rst_n = 1;
        clear_d();
        PC_d = 32'h100; RD1_d = 5; RD2_d = 7;
        tick();
        chk("first.PC", PC, 32'h100);
        chk("first.SrcA", SrcA, 32'd5);
        chk("first.SrcB", SrcB, 32'd7);
        check_all("first");
        // Forward priority
        Rs1_d = 3; RD1_d = 1;
        tick();
        RegWrite_m = 1; Rd_m = 3; ALUResult_m = 32'hAA;
        RegWrite_w = 1; Rd_w = 3; Result_w = 32'hBB;
        #1;
`ifdef ID_EX_FWD_EN
        chk("fwd.m_wins", SrcA, 32'hAA);
`else
        chk("nofwd.srca", SrcA, 32'd1);
`endif
        check_all("fwd1");
        RegWrite_m = 0;
        #1;
`ifdef ID_EX_FWD_EN
        chk("fwd.w", SrcA, 32'hBB);
`else
        chk("nofwd.srca_w", SrcA, 32'd1);
`endif
        check_all("fwd2");
        Rs1_d = 0; RD1_d = 9;
        tick();
        RegWrite_m = 1; Rd_m = 0; RegWrite_w = 1; Rd_w = 0;
        #1 chk("fwd.x0", SrcA, 32'd9);
        check_all("fwd3");
        // Immediate operand with forwarded store data
        RegWrite_m = 0; RegWrite_w = 0;
        ALUSrc_d = 1; ImmExt_d = 32'hFFFF_FFFC; Rs2_d = 4; RD2_d = 32'h12;
        tick();
        RegWrite_m = 1; Rd_m = 4; ALUResult_m = 32'h55;
        #1 chk("imm.SrcB", SrcB, 32'hFFFF_FFFC);
`ifdef ID_EX_FWD_EN
        chk("imm.wd", WriteData_e, 32'h55);
`else
        chk("imm.wd", WriteData_e, 32'h12);
`endif
        check_all("imm");
        // Load-use
        RegWrite_m = 0; ALUSrc_d = 0;
        RegWrite_d = 1; ResultSrc_d = 2'b01; Rd_d = 5; Rs1_d = 1; Rs2_d = 2;
        tick();
        Rs2_d = 5;
        #1 chk("lu.hit", {31'd0, lu_hazard}, 32'd1);
        check_all("lu1");
        Rd_d = 0;
        tick();
        chk("lu.x0", {31'd0, lu_hazard}, 32'd0);
        check_all("lu2");
        // ALU op writing x6 followed by a reader of x6
        ResultSrc_d = 2'b00; Rd_d = 6; Rs1_d = 0; Rs2_d = 0;
        tick();
        Rs1_d = 6;
        #1;
`ifdef ID_EX_FWD_EN
        chk("alu_dep.lu", {31'd0, lu_hazard}, 32'd0);
`else
        chk("alu_dep.lu", {31'd0, lu_hazard}, 32'd1);
`endif
        check_all("alu_dep");
        // Stall for two cycles, then stall+flush
        rand_d(); valid_d = 1; RegWrite_d = 1; MemWrite_d = 1;
        tick();
        saved_pc = PC;
        stall_e = 1;
        for (int i = 0; i < 2; i++) begin
            rand_d(); rand_mw(); tick(); check_all("stall");
            chk("stall.PC", PC, saved_pc);
        end
        flush_e = 1; rand_d();
        tick();
        chk("flush.ctl", {29'd0, valid_e, RegWrite_e, MemWrite_e}, 32'd0);
        check_all("flush");
        stall_e = 0; flush_e = 0;
        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            rand_d(); rand_mw();
            stall_e = ($urandom_range(0, 4) == 0);
            flush_e = ($urandom_range(0, 7) == 0);
            tick(); check_all("rnd");
            rand_mw();
            #1 check_all("rnd_mw");
        end
        // Asynchronous reset mid-stall
        stall_e = 1; flush_e = 0;
        @(negedge clk);
        #2 rst_n = 0; m = empty;
        #1 check_all("async_rst");
        chk("async_rst.PC", PC, 32'd0);
        @(negedge clk) rst_n = 1;
        stall_e = 0; rand_d();
        tick(); check_all("post_rst");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline register for the five-stage RV32I core. Each cycle it captures the decoded instruction: operands, immediate, register indices and control. It drives the ALU inputs SrcA, SrcB, ALUControl, PC and opcode for the execute stage. It also resolves RAW hazards by forwarding from the memory and writeback stages, and flags load-use hazards to the hazard unit.

## Interface
- XLEN, 32, datapath width (only 32 is supported)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- stall_e  in  1  hold the E register contents
- flush_e  in  1  load a bubble into E
- valid_d  in  1  D-stage instruction is valid
- PC_d  in  XLEN  D-stage PC
- opcode_d  in  7  instruction opcode
- ALUControl_d  in  4  ALU operation code
- ALUSrc_d  in  1  1: SrcB = immediate
- RD1_d, RD2_d  in  XLEN  register file read data
- ImmExt_d  in  XLEN  sign-extended immediate
- Rs1_d, Rs2_d, Rd_d  in  5  register indices
- RegWrite_d, MemWrite_d, Branch_d, Jump_d  in  1  control bits
- ResultSrc_d  in  2  00 ALU, 01 memory, 10 PC+4
- RegWrite_m  in  1  M-stage write enable
- Rd_m  in  5  M-stage destination
- ALUResult_m  in  XLEN  M-stage ALU result
- RegWrite_w  in  1  W-stage write enable
- Rd_w  in  5  W-stage destination
- Result_w  in  XLEN  W-stage writeback value
- SrcA, SrcB  out  XLEN  ALU operands
- ALUControl  out  4  registered ALU code
- PC  out  XLEN  registered PC
- opcode  out  7  registered opcode
- WriteData_e  out  XLEN  forwarded rs2 data for stores
- Rd_e  out  5  E-stage destination
- RegWrite_e, MemWrite_e, Branch_e, Jump_e, valid_e  out  1  registered control
- ResultSrc_e  out  2  registered result select
- lu_hazard  out  1  load-use hazard, combinational

## Operation
- The E register holds every *_d input, including Rs1/Rs2.
- Priority is rst_n low, then flush_e, then stall_e, then normal capture.
  - Reset and flush: every field is cleared to 0. This gives a bubble: valid_e=0 and all control 0.
  - Stall: all fields hold.
  - Normal: all fields load from the D inputs.
- Forwarding for operand A uses Rs1_e:
  - If RegWrite_m and Rd_m==Rs1_e and Rs1_e!=0, take ALUResult_m.
  - Otherwise, if RegWrite_w and Rd_w==Rs1_e and Rs1_e!=0, take Result_w.
  - Otherwise, take RD1_e.
  - The M stage always beats the W stage.
- Operand B (fwdB) is forwarded identically using Rs2_e.
- SrcA = fwdA.
- SrcB = ALUSrc_e ? ImmExt_e : fwdB.
- WriteData_e = fwdB, so it is forwarded even when ALUSrc_e=1.
- lu_hazard = valid_e & RegWrite_e & (ResultSrc_e==01) & (Rd_e!=0) & (Rd_e==Rs1_d | Rd_e==Rs2_d).
  - The hazard unit turns lu_hazard into a D stall plus flush_e.
- The block uses no opcode-specific logic. The ALU handles LUI and AUIPC itself.

## Timing
- Latency is one cycle from the D inputs to the registered E outputs.
- SrcA, SrcB, WriteData_e and lu_hazard are combinational. They come from the E register and the same-cycle M/W inputs.
- Reset values: every output is 0. With all fields cleared, Rs=0 suppresses forwarding, so SrcA=SrcB=WriteData_e=0 and lu_hazard=0.
- Reset takes effect immediately on rst_n falling, including mid-stall. The first capture happens on the first clk edge after rst_n rises.
- flush_e and stall_e asserted in the same cycle: flush wins.
- While stalled, the forwarded operands still track the changing M/W inputs. The register contents do not change.
- Rd_m == Rd_w == Rs1_e, both writing: ALUResult_m is selected.

## Configuration
- ID_EX_FWD_EN defined: forwarding operates as described above.
- ID_EX_FWD_EN undefined:
  - SrcA = RD1_e, and fwdB = RD2_e.
  - The *_m and *_w forwarding inputs are ignored.
  - lu_hazard widens to any valid E-stage register write, i.e. the ResultSrc_e==01 term is dropped.
  - The external hazard unit must stall on M and W conflicts.

## Test plan
- Reset: hold rst_n=0 with random inputs on the D ports -> every output is 0. Release, then capture PC_d=0x100, RD1_d=5, RD2_d=7, ALUSrc_d=0 -> the next cycle shows PC=0x100, SrcA=5, SrcB=7.
- Forward priority: Rs1_e=3, RD1_e=1, M writes x3=0xAA, W writes x3=0xBB -> SrcA=0xAA. Drop RegWrite_m -> SrcA=0xBB. Set Rs1_e=0 with both writing x0 -> SrcA=RD1_e.
- Immediate with store: ALUSrc_e=1, ImmExt=0xFFFFFFFC, Rs2_e=4, M writes x4=0x55 -> SrcB=0xFFFFFFFC, WriteData_e=0x55.
- Load-use: E holds a load (ResultSrc 01, RegWrite 1) to x5, and Rs2_d=5 -> lu_hazard=1. Same case with Rd_e=0 -> lu_hazard=0.
- Stall then flush: stall_e=1 for 2 cycles -> outputs held. stall_e=1 and flush_e=1 together -> the next cycle has valid_e=0, RegWrite_e=0, MemWrite_e=0.
- With ID_EX_FWD_EN undefined: M writes the matching register -> SrcA=RD1_e. An ALU op in E writing x6 with Rs1_d=6 -> lu_hazard=1.
